// File: rtl/mant_div_seq.sv
// Sequential restoring mantissa divider: Q = floor(A*2^WIDTH/B), one quotient bit per cycle.
// Optional remainder-nonzero flag built only when MANT_DIV_STICKY_EN is defined.
module mant_div_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   Q,
  output logic             sticky,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [4:0] ITERS = 5'(WIDTH + 1);

  state_t           state_q;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH:0]   q_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       cnt_q;
  logic             ready_q, done_q, err_q;
  logic             ge;
  logic [WIDTH:0]   diff;

  // R stays below 2*B, so the shifted value always fits in WIDTH+1 bits.
  always_comb begin
    ge   = (r_q >= {1'b0, b_q});
    diff = r_q - {1'b0, b_q};
    r_d  = ge ? (diff << 1) : (r_q << 1);
  end

`ifdef MANT_DIV_STICKY_EN
  logic sticky_q;
  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MANT_DIV_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            b_q <= B;
            r_q <= {1'b0, A};
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
            if (!B[WIDTH-1]) begin
              // Unnormalized divisor: report saturated quotient without iterating.
              q_q     <= '1;
              err_q   <= 1'b1;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              q_q     <= '0;
              err_q   <= 1'b0;
              cnt_q   <= ITERS;
              ready_q <= 1'b0;
              state_q <= S_RUN;
            end
          end else if (state_q == S_DONE) begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= {q_q[WIDTH-1:0], ge};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= (r_d != '0);
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign Q     = q_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Randomized and directed bench for mant_div_seq against an arithmetic quotient model.
module tb_mant_div_seq;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic         ready, done, sticky, err;
  logic [W:0]   Q;

  int n_assert = 0;
  int n_fail   = 0;

  mant_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .done(done), .Q(Q), .sticky(sticky), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division of A*2^W by B.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W:0] q, output logic s, output logic e);
    longint num;
    if (!b[W-1]) begin
      q = '1; s = 1'b0; e = 1'b1;
    end else begin
      num = longint'(a) << W;
      q = (W+1)'(num / longint'(b));
`ifdef MANT_DIV_STICKY_EN
      s = (num % longint'(b)) != 0;
`else
      s = 1'b0;
`endif
      e = 1'b0;
    end
  endfunction

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] eq;
    logic       es, ee;
    int         n;
    model(a, b, eq, es, ee);
    start = 1'b1; A = a; B = b;
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    chk({tag, ".ready_busy"}, 64'(ready), 64'(ee));
    n = 0;
    while (!done && n < 40) begin
      if (n > 0) chk({tag, ".ready_run"}, 64'(ready), 64'(0));
      step();
      n++;
    end
    chk({tag, ".done"}, 64'(done), 64'(1));
    chk({tag, ".latency"}, 64'(n), ee ? 64'(0) : 64'(W+1));
    chk({tag, ".Q"}, 64'(Q), 64'(eq));
    chk({tag, ".sticky"}, 64'(sticky), 64'(es));
    chk({tag, ".err"}, 64'(err), 64'(ee));
    chk({tag, ".ready_done"}, 64'(ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   eq, capq;
    logic         es, ee;
    int           pulses, at;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    step(); step();
    rst = 1'b0;
    chk("reset.ready", 64'(ready), 64'(1));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.Q", 64'(Q), 64'(0));
    chk("reset.sticky", 64'(sticky), 64'(0));
    chk("reset.err", 64'(err), 64'(0));
    step();

    do_div("one", 24'h800000, 24'h800000);
    step();
    chk("one.done_pulse", 64'(done), 64'(0));
    chk("one.Q_hold", 64'(Q), 64'h1000000);
    do_div("thirds", 24'h800000, 24'hC00000);
    do_div("maxa", 24'hFFFFFF, 24'h800000);   // back-to-back: accepted from DONE
    do_div("onehalf", 24'hC00000, 24'h800000);
    do_div("unnorm", 24'h123456, 24'h400000);
    do_div("recover", 24'h800000, 24'h800000);
    do_div("minmax", 24'h800000, 24'hFFFFFF);

    for (int i = 0; i < 16; i++) begin
      a = W'($urandom) | ((i % 4 != 3) ? 24'h800000 : 24'h0);
      b = W'($urandom) | 24'h800000;
      if (i % 6 == 5) b[W-1] = 1'b0;
      do_div($sformatf("rnd%0d", i), a, b);
      if (i % 3 == 0) step();
    end

    // Start pulse during RUN must be ignored.
    step();
    a = 24'hABCDEF; b = 24'h9ABCDE;
    model(a, b, eq, es, ee);
    start = 1'b1; A = a; B = b;
    step();
    start = 1'b0;
    pulses = 0; at = -1; capq = '0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 10) begin start = 1'b1; A = 24'h812345; B = 24'h400001; end
      if (c == 11) start = 1'b0;
      if (done) begin pulses++; at = c - 1; capq = Q; end
      step();
    end
    chk("ignore.pulses", 64'(pulses), 64'(1));
    chk("ignore.latency", 64'(at), 64'(W+1));
    chk("ignore.Q", 64'(capq), 64'(eq));
    chk("ignore.err", 64'(err), 64'(0));

    // Reset in the middle of RUN aborts silently.
    start = 1'b1; A = 24'hC00000; B = 24'h800000;
    step();
    start = 1'b0;
    for (int c = 0; c < 12; c++) step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("abort.done", 64'(done), 64'(0));
    chk("abort.Q", 64'(Q), 64'(0));
    chk("abort.sticky", 64'(sticky), 64'(0));
    chk("abort.err", 64'(err), 64'(0));
    chk("abort.ready", 64'(ready), 64'(1));
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) pulses++;
      step();
    end
    chk("abort.no_done", 64'(pulses), 64'(0));
    do_div("after_abort", 24'hFFFFFF, 24'h800001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
